sha256_seq_ctrl: RTL
====================

SHA256_SEQ_CTRL -- requirements
Module: sha256_seq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named iClk and iReset_n.
REQ-002 SHALL provide these ports:
- iClk, in, 1: rising-edge clock.
- iReset_n, in, 1: asynchronous active-low reset.
- iChipselect_n, in, 1: bus select, active low.
- iWrite_n, in, 1: bus write strobe, active low.
- iRead_n, in, 1: bus read strobe, active low.
- iAddress, in, 5: register word address.
- iData, in, 32: write data.
- oData, out, 32: registered read data.
- oIrq, out, 1: completion/error interrupt, level.
- oCore_start, out, 1: one-cycle start pulse to the compression core.
- oCore_M, out, 512: message block; word 0 is in [511:480].
- oCore_H, out, 256: chaining input a..h; a is in [255:224].
- iCore_done, in, 1: one-cycle done pulse from the core.
- iCore_H, in, 256: core result a..h, before feed-forward.

Function
REQ-003 SHALL map addresses as follows:
- 0x00-0x0F: message words W0-W15 (read/write).
- 0x10: CTRL (write only). bit0 = START, bit1 = INIT, bit2 = IRQ_EN.
- 0x11: STATUS. bit0 = BUSY, bit1 = DONE, bit2 = ERR.
- 0x12: BLKCNT, 16-bit block counter, zero-extended on read.
- 0x18-0x1F: digest words H0-H7 (read only).
- All other addresses: reads return 0; writes are ignored.
REQ-004 A bus access SHALL require iChipselect_n=0; write has priority when iWrite_n and iRead_n are both low.
REQ-005 oData SHALL update on the clock edge after a read and SHALL hold its value otherwise.
REQ-006 FSM states SHALL be IDLE, LAUNCH, WAIT and ACCUM.
REQ-007 IDLE->LAUNCH SHALL occur on a CTRL write with START=1.
- If INIT=1, the chaining register SHALL be loaded with the SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and BLKCNT SHALL be cleared.
- If INIT=0, the current digest SHALL be kept as the chaining value.
- In the same edge: BUSY=1, DONE=0, ERR=0.
REQ-008 LAUNCH SHALL last exactly one cycle.
- oCore_start=1 during LAUNCH.
- oCore_M and oCore_H SHALL be stable from LAUNCH until the block leaves WAIT.
- Next state is WAIT.
REQ-009 WAIT SHALL count cycles with a 7-bit timer.
- iCore_done=1 -> latch iCore_H, go to ACCUM.
- Timer reaches 100 without done -> ERR=1, BUSY=0, go to IDLE; digest unchanged.
REQ-010 ACCUM SHALL last one cycle and then return to IDLE.
- Digest word Hi becomes Hi + iCore_H word i, modulo 2^32 per word, with no carry between words.
- BLKCNT increments, wrapping 0xFFFF->0x0000.
- BUSY=0, DONE=1.
REQ-011 oCore_H SHALL always drive the chaining register; the digest registers SHALL equal the chaining register.
REQ-012 A CTRL write with START=1 while BUSY=1 SHALL be ignored and SHALL set ERR=1 without disturbing the operation in progress.
REQ-013 A message-word write while BUSY=1 SHALL be dropped and SHALL set ERR=1.
REQ-014 A STATUS write SHALL clear DONE and/or ERR where the written bit is 1 (write-1-to-clear); BUSY is not writable.
REQ-015 If a clear and a set of the same bit fall in the same cycle, the set SHALL win.
REQ-016 iCore_done seen outside WAIT SHALL be ignored.
REQ-017 oIrq SHALL equal IRQ_EN AND (DONE OR ERR).
REQ-018 IRQ_EN SHALL be updated on every CTRL write regardless of START.

Reset
REQ-019 Asserting iReset_n=0 at any time, including mid-operation, SHALL immediately set:
- FSM = IDLE, all STATUS bits 0, IRQ_EN=0, BLKCNT=0.
- Message words = 0, digest/chaining = 0.
- oData=0, oCore_start=0, oIrq=0.
REQ-020 After reset release, no core start SHALL occur until a new START write.

Verification
REQ-021 Single block with a real core: write the padded "abc" block (W0=61626380, W15=00000018, others 0), then CTRL=0x3.
- Required: DONE=1, BLKCNT=1, H0-H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-022 Two-block chaining: run the 448-bit NIST message "abcdbcdecdefdefg...nopq" as block 1 with CTRL=0x3, then block 2 with CTRL=0x1.
- Required: digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, BLKCNT=2.
REQ-023 Timeout: model core never asserts done.
- Required: ERR=1 and BUSY=0 exactly 100 cycles after WAIT entry; digest unchanged; oIrq=1 if IRQ_EN=1.
REQ-024 Busy collisions: during WAIT, write W3=0xDEADBEEF and CTRL=0x1.
- Required: W3 unchanged, ERR=1, exactly one oCore_start pulse seen, the operation still completes with DONE=1.
REQ-025 Per-word wrap: model core returns all words FFFFFFFF with INIT=1.
- Required: H0 = 6a09e666 (no carry into other words); STATUS write 0x6 clears DONE and ERR and drops oIrq.
REQ-026 Reset mid-WAIT: assert iReset_n=0, then release.
- Required: all registers 0, FSM in IDLE; a late iCore_done is ignored.

Source files
------------

// File: rtl/sha256_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_seq_ctrl
//
// Bus-mapped sequencer around an external SHA-256 compression core.
// Software loads the 16 message words, writes CTRL to launch a block, and
// reads the running digest back. The sequencer pulses the core, waits for
// its result (with a timeout), and performs the feed-forward addition into
// the chaining register.
//
// Ports
//   iClk           rising-edge clock
//   iReset_n       asynchronous active-low reset
//   iChipselect_n  bus select, active low
//   iWrite_n       bus write strobe, active low (wins over read)
//   iRead_n        bus read strobe, active low
//   iAddress[4:0]  register word address
//   iData[31:0]    write data
//   oData[31:0]    registered read data, holds between reads
//   oIrq           level interrupt = IRQ_EN & (DONE | ERR)
//   oCore_start    one-cycle start pulse to the core
//   oCore_M[511:0] message block, word 0 in [511:480]
//   oCore_H[255:0] chaining value a..h, a in [255:224]
//   iCore_done     one-cycle done pulse from the core
//   iCore_H[255:0] core result a..h, before feed-forward
//
// Register map
//   0x00-0x0F  W0..W15 (rw)      0x10  CTRL  (wo) START/INIT/IRQ_EN
//   0x11  STATUS BUSY/DONE/ERR   0x12  BLKCNT (ro, 16 bit)
//   0x18-0x1F  H0..H7 (ro)       others read 0, writes ignored
// ---------------------------------------------------------------------------
module sha256_seq_ctrl (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iChipselect_n,
    input  logic         iWrite_n,
    input  logic         iRead_n,
    input  logic [4:0]   iAddress,
    input  logic [31:0]  iData,
    output logic [31:0]  oData,
    output logic         oIrq,
    output logic         oCore_start,
    output logic [511:0] oCore_M,
    output logic [255:0] oCore_H,
    input  logic         iCore_done,
    input  logic [255:0] iCore_H
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCUM  = 2'd3
    } state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [4:0] ADDR_CTRL   = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h11;
    localparam logic [4:0] ADDR_BLKCNT = 5'h12;

    // Timer value in the last WAIT cycle before the timeout fires; the
    // timer starts at 0 on WAIT entry, so this trips 100 cycles later.
    localparam logic [6:0] WAIT_LAST = 7'd99;

    // -----------------------------------------------------------------------
    // Word helpers
    // -----------------------------------------------------------------------

    // Message word idx (word 0 is the most significant word).
    function automatic logic [31:0] get_word16(input logic [511:0] v,
                                               input logic [3:0]   idx);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (idx == 4'(i)) begin
                r = v[32*(15-i) +: 32];
            end
        end
        return r;
    endfunction

    // Replace message word idx with w.
    function automatic logic [511:0] put_word16(input logic [511:0] v,
                                                input logic [3:0]   idx,
                                                input logic [31:0]  w);
        logic [511:0] r;
        r = v;
        for (int i = 0; i < 16; i++) begin
            if (idx == 4'(i)) begin
                r[32*(15-i) +: 32] = w;
            end
        end
        return r;
    endfunction

    // Digest word idx (word 0 = a, most significant).
    function automatic logic [31:0] get_word8(input logic [255:0] v,
                                              input logic [2:0]   idx);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                r = v[32*(7-i) +: 32];
            end
        end
        return r;
    endfunction

    // Feed-forward: independent 32-bit additions, no carry between words.
    function automatic logic [255:0] add_words(input logic [255:0] a,
                                               input logic [255:0] b);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t         state_q,  state_d;
    logic [6:0]     timer_q,  timer_d;
    logic [511:0]   msg_q,    msg_d;
    logic [255:0]   chain_q,  chain_d;
    logic [255:0]   result_q, result_d;
    logic [15:0]    blkcnt_q, blkcnt_d;
    logic           busy_q,   busy_d;
    logic           done_q,   done_d;
    logic           err_q,    err_d;
    logic           irq_en_q, irq_en_d;
    logic [31:0]    rdata_q,  rdata_d;
    logic           irq_q,    irq_d;
    logic           start_q,  start_d;

    logic           wr_s;
    logic           rd_s;
    logic           ctrl_wr_s;
    logic           status_wr_s;
    logic           msg_wr_s;
    logic           start_req_s;
    logic [31:0]    rd_word_s;

    // Bus decode; a simultaneous read and write is treated as a write only.
    always_comb begin
        wr_s        = (iChipselect_n == 1'b0) && (iWrite_n == 1'b0);
        rd_s        = (iChipselect_n == 1'b0) && (iRead_n == 1'b0) && (iWrite_n == 1'b1);
        ctrl_wr_s   = wr_s && (iAddress == ADDR_CTRL);
        status_wr_s = wr_s && (iAddress == ADDR_STATUS);
        msg_wr_s    = wr_s && (iAddress[4] == 1'b0);
        start_req_s = ctrl_wr_s && (iData[0] == 1'b1);
    end

    // Read data multiplexer.
    always_comb begin
        rd_word_s = 32'd0;
        if (iAddress[4] == 1'b0) begin
            rd_word_s = get_word16(msg_q, iAddress[3:0]);
        end else if (iAddress == ADDR_STATUS) begin
            rd_word_s = {29'd0, err_q, done_q, busy_q};
        end else if (iAddress == ADDR_BLKCNT) begin
            rd_word_s = {16'd0, blkcnt_q};
        end else if (iAddress[4:3] == 2'b11) begin
            rd_word_s = get_word8(chain_q, iAddress[2:0]);
        end else begin
            rd_word_s = 32'd0;
        end
    end

    // Next-state logic: bus side effects, sequencing and status flags.
    // Status clears are applied before any set so that a set in the same
    // cycle overrides the write-1-to-clear.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        msg_d    = msg_q;
        chain_d  = chain_q;
        result_d = result_q;
        blkcnt_d = blkcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;
        start_d  = 1'b0;

        if (rd_s) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = rdata_q;
        end

        if (ctrl_wr_s) begin
            irq_en_d = iData[2];
        end else begin
            irq_en_d = irq_en_q;
        end

        if (status_wr_s) begin
            if (iData[1] == 1'b1) begin
                done_d = 1'b0;
            end else begin
                done_d = done_q;
            end
            if (iData[2] == 1'b1) begin
                err_d = 1'b0;
            end else begin
                err_d = err_q;
            end
        end else begin
            done_d = done_q;
            err_d  = err_q;
        end

        // The core is reading the message words while busy, so writes then
        // are refused and flagged.
        if (msg_wr_s) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                msg_d = put_word16(msg_q, iAddress[3:0], iData);
            end
        end else begin
            msg_d = msg_q;
        end

        // A second START while a block is in flight is refused and flagged.
        if (start_req_s && busy_q) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req_s) begin
                    state_d = ST_LAUNCH;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    timer_d = 7'd0;
                    if (iData[1] == 1'b1) begin
                        chain_d  = SHA256_IV;
                        blkcnt_d = 16'd0;
                    end else begin
                        chain_d  = chain_q;
                        blkcnt_d = blkcnt_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                timer_d = 7'd0;
            end
            ST_WAIT: begin
                if (iCore_done) begin
                    result_d = iCore_H;
                    state_d  = ST_ACCUM;
                end else if (timer_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 7'd1;
                end
            end
            ST_ACCUM: begin
                chain_d  = add_words(chain_q, result_q);
                blkcnt_d = blkcnt_q + 16'd1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        irq_d = irq_en_d & (done_d | err_d);
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= 7'd0;
            msg_q    <= 512'd0;
            chain_q  <= 256'd0;
            result_q <= 256'd0;
            blkcnt_q <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            msg_q    <= msg_d;
            chain_q  <= chain_d;
            result_q <= result_d;
            blkcnt_q <= blkcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            start_q  <= start_d;
        end
    end

    assign oData       = rdata_q;
    assign oIrq        = irq_q;
    assign oCore_start = start_q;
    assign oCore_M     = msg_q;
    assign oCore_H     = chain_q;

endmodule
